// File: rtl/fft_twiddle_addr_gen.sv
// Twiddle LUT address generator for a radix-2 DIT FFT: walks every butterfly of every stage.
// Define TWIDDLE_SIN_ADDR_EN to add the quarter-period-shifted sine address output.
module fft_twiddle_addr_gen #(
  parameter int unsigned N_POINTS = 512,
  parameter int unsigned LOG2N    = 9,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [3:0]        stage,
  output logic [LOG2N-2:0]  bfly,
  output logic              last,
  output logic              busy,
`ifdef TWIDDLE_SIN_ADDR_EN
  output logic [ADDR_W-1:0] addr_sin,
`endif
  output logic              done
);

  localparam int unsigned BW       = LOG2N - 1;
  localparam int unsigned SHIFT_UP = ADDR_W - LOG2N;
  localparam logic [BW-1:0] BFLY_MAX  = BW'(N_POINTS / 2 - 1);
  localparam logic [BW-1:0] BFLY_ONES = '1;
  localparam logic [3:0]    STAGE_MAX = 4'(LOG2N - 1);
`ifdef TWIDDLE_SIN_ADDR_EN
  localparam int unsigned SIN_OFF = 3 << (ADDR_W - 2);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [3:0]        stage_q, stage_d;
  logic [BW-1:0]     bfly_q, bfly_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef TWIDDLE_SIN_ADDR_EN
  logic [ADDR_W-1:0] addr_sin_q, addr_sin_d;
`endif

  // addr = ((b mod 2^s) << (LOG2N-1-s)) << (ADDR_W-LOG2N)
  function automatic logic [ADDR_W-1:0] twiddle_addr(input logic [3:0] s, input logic [BW-1:0] b);
    logic [BW-1:0] mask;
    logic [BW-1:0] k;
    mask = ~(BFLY_ONES << s);
    k    = (b & mask) << (4'(BW) - s);
    return ADDR_W'(k) << SHIFT_UP;
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    bfly_d       = bfly_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    last_d       = last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef TWIDDLE_SIN_ADDR_EN
    addr_sin_d   = addr_sin_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RUN;
          stage_d      = '0;
          bfly_d       = '0;
          addr_d       = '0;
          addr_valid_d = 1'b1;
          busy_d       = 1'b1;
          last_d       = 1'b0;
`ifdef TWIDDLE_SIN_ADDR_EN
          addr_sin_d   = ADDR_W'(SIN_OFF);
`endif
        end
      end
      S_RUN: begin
        if (addr_ready) begin
          if (last_q) begin
            state_d      = S_FIN;
            addr_valid_d = 1'b0;
            busy_d       = 1'b0;
            last_d       = 1'b0;
            done_d       = 1'b1;
          end else begin
            if (bfly_q == BFLY_MAX) begin
              bfly_d  = '0;
              stage_d = stage_q + 4'd1;
            end else begin
              bfly_d  = bfly_q + BW'(1);
            end
            last_d = (stage_d == STAGE_MAX) && (bfly_d == BFLY_MAX);
            addr_d = twiddle_addr(stage_d, bfly_d);
`ifdef TWIDDLE_SIN_ADDR_EN
            addr_sin_d = addr_d + ADDR_W'(SIN_OFF);
`endif
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      stage_q      <= '0;
      bfly_q       <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef TWIDDLE_SIN_ADDR_EN
      addr_sin_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      bfly_q       <= bfly_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef TWIDDLE_SIN_ADDR_EN
      addr_sin_q   <= addr_sin_d;
`endif
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign stage      = stage_q;
  assign bfly       = bfly_q;
  assign last       = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef TWIDDLE_SIN_ADDR_EN
  assign addr_sin   = addr_sin_q;
`endif

endmodule

// File: doc/fft_twiddle_addr_gen.md
Name: fft_twiddle_addr_gen

Overview:
- Upstream stage of the cosine twiddle LUT in the radix-2 DIT FFT datapath.
- Walks every butterfly of every stage of an N_POINTS transform and emits the matching LUT address, one per accepted handshake.
- The address drives the LUT `addr` input directly.
- The stage/butterfly tags and `last` flag travel alongside to the butterfly scheduler.

Parameters:
- N_POINTS, 512, transform size; power of two, at least 4.
- LOG2N, 9, log2(N_POINTS).
- ADDR_W, 10, LUT address width. The LUT holds one full cosine period over 2^ADDR_W entries. ADDR_W >= LOG2N.

Ports:
- Clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse; begins a full address sweep when idle.
- addr_ready  in  1  downstream accepts the current address.
- addr  out  ADDR_W  twiddle LUT address.
- addr_valid  out  1  addr/stage/bfly/last are valid.
- stage  out  4  current FFT stage s, range 0..LOG2N-1.
- bfly  out  LOG2N-1  butterfly index b within stage, range 0..N_POINTS/2-1.
- last  out  1  high with the final address of the sweep (s=LOG2N-1, b=N_POINTS/2-1).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last address is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - addr, stage, bfly, addr_valid, last, busy and done all clear to 0.
- FSM states:
  - IDLE: wait for start.
  - RUN: present addresses.
  - FIN: one cycle; done=1, busy=0; then return to IDLE.
- IDLE -> RUN when start=1 at a rising edge.
  - Next cycle: addr_valid=1, busy=1, s=0, b=0.
  - Latency start -> first valid address is 1 cycle.
- Address arithmetic, all registered:
  - j = b mod 2^s.
  - k = j << (LOG2N-1-s).
  - addr = k << (ADDR_W-LOG2N).
  - addr is computed from the counters being presented, so it is always consistent with stage/bfly.
- Handshake:
  - A transfer occurs when addr_valid & addr_ready at a rising edge.
  - While addr_ready=0, addr, stage, bfly and last hold stable and addr_valid stays 1.
  - On transfer: b increments.
  - At b=N_POINTS/2-1, b wraps to 0 and s increments.
  - A transfer with last=1 moves the FSM to FIN: addr_valid=0 and done=1 in that next cycle.
- Back-to-back: with addr_ready tied 1, one address per cycle. The full sweep is N_POINTS/2*LOG2N transfers (2304 at defaults).
- start while busy or in FIN: ignored. No queuing.
- start in the same cycle FIN returns to IDLE: ignored. A new start is required once IDLE.
- Reset mid-sweep: immediate return to IDLE with all outputs 0. No done pulse. The next start restarts from s=0, b=0.
- addr_ready while addr_valid=0: no effect.

Optional Feature:
- Macro: TWIDDLE_SIN_ADDR_EN.
- Defined:
  - Adds output `addr_sin`, width ADDR_W.
  - addr_sin = (addr + 3*2^ADDR_W/4) mod 2^ADDR_W, i.e. cos(theta - pi/2) = sin(theta).
  - A second port of the same cosine LUT then returns the sine term.
  - Registered in the same cycle as addr, held under the same handshake, reset to 0.
- Undefined: port and logic absent; the rest of the block is identical.

Test Plan:
- Reset released, start pulse, addr_ready=1 -> addr_valid rises 1 cycle after start; stage 0 emits 256 addresses, all 0; busy=1 throughout.
- Continue stage 1, b=0..3 -> addr 0,256,0,256; stage 8, b=0,1,2,3 -> addr 0,2,4,6; b=255 -> addr 510 with last=1; next cycle done=1, busy=0; total transfers 2304.
- Backpressure: drop addr_ready for 5 cycles at s=8, b=10 -> addr=20, stage=8, bfly=10 hold stable with addr_valid=1; on release the next transfer presents b=11 (addr=22).
- Assert reset=0 at s=3, b=100 -> all outputs 0 immediately, no done pulse; a new start restarts at s=0, b=0, addr=0.
- Pulse start at s=2 mid-sweep and again in the FIN cycle -> both ignored; sweep count unchanged; exactly one done pulse.
- With TWIDDLE_SIN_ADDR_EN: addr=0 -> addr_sin=768; addr=256 -> addr_sin=0; addr=510 -> addr_sin=254.
